// File: rtl/hazard_freeze_unit_pkg.sv
// Shared types and defaults for the hazard/freeze control slice.
// The memory-wait FSM states, the event counter width default and a register-match helper.
package hazard_freeze_unit_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam int CNT_W_DEFAULT = 16;

  function automatic logic reg_hit(input logic [3:0] src, input logic [3:0] dest,
                                   input logic wb_en);
    return wb_en && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational data-hazard detector comparing decode sources against in-flight destinations.
// Define FORWARDING_EN to flag only load-use hazards (forwarding resolves the rest).
module hazard_detect
  import hazard_freeze_unit_pkg::*;
(
  input  logic [3:0] ID_src1,
  input  logic [3:0] ID_src2,
  input  logic       ID_two_src,
  input  logic       ID_uses_src1,
  input  logic [3:0] EX_Dest,
  input  logic       EX_WB_EN,
  input  logic       EX_MEM_R_EN,
  input  logic [3:0] MEM_Dest,
  input  logic       MEM_WB_EN,
  output logic       hz
);

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{MEM_Dest, MEM_WB_EN, EX_WB_EN};

  always_comb begin
    hz = EX_MEM_R_EN &&
         ((ID_uses_src1 && (ID_src1 == EX_Dest)) ||
          (ID_two_src   && (ID_src2 == EX_Dest)));
  end
`else
  always_comb begin
    hz = (ID_uses_src1 && (reg_hit(ID_src1, EX_Dest, EX_WB_EN) ||
                           reg_hit(ID_src1, MEM_Dest, MEM_WB_EN))) ||
         (ID_two_src   && (reg_hit(ID_src2, EX_Dest, EX_WB_EN) ||
                           reg_hit(ID_src2, MEM_Dest, MEM_WB_EN)));
  end
`endif

endmodule

// File: rtl/hazard_freeze_unit.sv
// Pipeline freeze/flush control: memory-wait FSM, priority mux (mem_stall > br > hz),
// saturating debug counters. Build option: FORWARDING_EN (see hazard_detect).
module hazard_freeze_unit
  import hazard_freeze_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ID_src1,
  input  logic [3:0]       ID_src2,
  input  logic             ID_two_src,
  input  logic             ID_uses_src1,
  input  logic [3:0]       EX_Dest,
  input  logic             EX_WB_EN,
  input  logic             EX_MEM_R_EN,
  input  logic             EX_B_taken,
  input  logic [3:0]       MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_Freeze,
  output logic             IF_Reg_Freeze,
  output logic             IF_Reg_Flush,
  output logic             ID_Reg_Freeze,
  output logic             ID_Reg_Flush,
  output logic             Pipe_Freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic             mem_timeout_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  mem_state_t        state, state_next;
  logic              hz, mem_stall, sel_br, sel_hz;
  logic [WAIT_W-1:0] wait_cnt;

  hazard_detect u_hazard_detect (
    .ID_src1      (ID_src1),
    .ID_src2      (ID_src2),
    .ID_two_src   (ID_two_src),
    .ID_uses_src1 (ID_uses_src1),
    .EX_Dest      (EX_Dest),
    .EX_WB_EN     (EX_WB_EN),
    .EX_MEM_R_EN  (EX_MEM_R_EN),
    .MEM_Dest     (MEM_Dest),
    .MEM_WB_EN    (MEM_WB_EN),
    .hz           (hz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    mem_stall     = 1'b0;
    sel_br        = 1'b0;
    sel_hz        = 1'b0;
    PC_Freeze     = 1'b0;
    IF_Reg_Freeze = 1'b0;
    IF_Reg_Flush  = 1'b0;
    ID_Reg_Freeze = 1'b0;
    ID_Reg_Flush  = 1'b0;
    Pipe_Freeze   = 1'b0;

    case (state)
      MEM_IDLE: begin
        mem_stall = mem_req & ~mem_ready;
        if (mem_req && !mem_ready) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_stall = ~mem_ready;
        if (mem_ready) state_next = MEM_IDLE;
      end
      default: state_next = MEM_IDLE;
    endcase

    sel_br = ~mem_stall & EX_B_taken;
    sel_hz = ~mem_stall & ~EX_B_taken & hz;

    // Flush takes precedence inside the stage register, so a freeze row never flushes.
    if (mem_stall) begin
      PC_Freeze     = 1'b1;
      IF_Reg_Freeze = 1'b1;
      ID_Reg_Freeze = 1'b1;
      Pipe_Freeze   = 1'b1;
    end else if (sel_br) begin
      IF_Reg_Flush  = 1'b1;
      ID_Reg_Flush  = 1'b1;
    end else if (sel_hz) begin
      PC_Freeze     = 1'b1;
      IF_Reg_Freeze = 1'b1;
      ID_Reg_Flush  = 1'b1;
    end
  end

  // Length of the current stall run; the error is sticky and the access is never aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WAIT_LAST) mem_timeout_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      mem_wait_cnt <= '0;
    end else begin
      if (sel_hz && (stall_cnt != '1))       stall_cnt    <= stall_cnt + 1'b1;
      if (sel_br && (flush_cnt != '1))       flush_cnt    <= flush_cnt + 1'b1;
      if (mem_stall && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_freeze_unit.sv
// Self-checking bench for hazard_freeze_unit: directed scenarios plus random traffic
// against a behavioural model. Follows FORWARDING_EN when it is defined for the build.
module tb_hazard_freeze_unit;

  localparam int MEM_TIMEOUT = 255;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       ID_src1, ID_src2, EX_Dest, MEM_Dest;
  logic             ID_two_src, ID_uses_src1, EX_WB_EN, EX_MEM_R_EN, EX_B_taken;
  logic             MEM_WB_EN, mem_req, mem_ready;
  logic             PC_Freeze, IF_Reg_Freeze, IF_Reg_Flush;
  logic             ID_Reg_Freeze, ID_Reg_Flush, Pipe_Freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, mem_wait_cnt;
  logic             mem_timeout_err;

  int checks = 0;
  int fails  = 0;

  // Behavioural model: outstanding-access flag, stall run length, counters, sticky error.
  bit m_waiting;
  int m_run, m_stall, m_flush, m_memw;
  bit m_err;

  hazard_freeze_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_src1         (ID_src1),
    .ID_src2         (ID_src2),
    .ID_two_src      (ID_two_src),
    .ID_uses_src1    (ID_uses_src1),
    .EX_Dest         (EX_Dest),
    .EX_WB_EN        (EX_WB_EN),
    .EX_MEM_R_EN     (EX_MEM_R_EN),
    .EX_B_taken      (EX_B_taken),
    .MEM_Dest        (MEM_Dest),
    .MEM_WB_EN       (MEM_WB_EN),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .PC_Freeze       (PC_Freeze),
    .IF_Reg_Freeze   (IF_Reg_Freeze),
    .IF_Reg_Flush    (IF_Reg_Flush),
    .ID_Reg_Freeze   (ID_Reg_Freeze),
    .ID_Reg_Flush    (ID_Reg_Flush),
    .Pipe_Freeze     (Pipe_Freeze),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_wait_cnt    (mem_wait_cnt),
    .mem_timeout_err (mem_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                               input logic uses1, input logic [3:0] exd, input logic exwb,
                               input logic exrd, input logic br, input logic [3:0] memd,
                               input logic memwb, input logic req, input logic rdy);
    ID_src1 = s1;  ID_src2 = s2;  ID_two_src = two;  ID_uses_src1 = uses1;
    EX_Dest = exd; EX_WB_EN = exwb; EX_MEM_R_EN = exrd; EX_B_taken = br;
    MEM_Dest = memd; MEM_WB_EN = memwb; mem_req = req; mem_ready = rdy;
  endtask

  function automatic bit modelHz();
    bit h1, h2;
`ifdef FORWARDING_EN
    h1 = ID_uses_src1 && EX_MEM_R_EN && (ID_src1 == EX_Dest);
    h2 = ID_two_src   && EX_MEM_R_EN && (ID_src2 == EX_Dest);
`else
    h1 = ID_uses_src1 && ((EX_WB_EN && ID_src1 == EX_Dest) || (MEM_WB_EN && ID_src1 == MEM_Dest));
    h2 = ID_two_src   && ((EX_WB_EN && ID_src2 == EX_Dest) || (MEM_WB_EN && ID_src2 == MEM_Dest));
`endif
    return h1 || h2;
  endfunction

  function automatic logic [5:0] outVec();
    return {PC_Freeze, IF_Reg_Freeze, IF_Reg_Flush, ID_Reg_Freeze, ID_Reg_Flush, Pipe_Freeze};
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    checkOutput({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    checkOutput({tag, "_memw_cnt"},  32'(mem_wait_cnt), 32'(m_memw));
    checkOutput({tag, "_timeout"},   32'(mem_timeout_err), 32'(m_err));
  endtask

  // One pipeline cycle: entered at posedge+1 with inputs already applied.
  task automatic step(input string tag);
    bit stall, br, hz;
    logic [5:0] exp;
    #2;
    stall = m_waiting ? !mem_ready : (mem_req && !mem_ready);
    br    = !stall && EX_B_taken;
    hz    = !stall && !EX_B_taken && modelHz();
    if (stall)   exp = 6'b110101;
    else if (br) exp = 6'b001010;
    else if (hz) exp = 6'b110010;
    else         exp = 6'b000000;
    checkOutput({tag, "_ctrl"}, 32'(outVec()), 32'(exp));
    @(posedge clk);
    #1;
    if (hz && m_stall < CNT_MAX) m_stall++;
    if (br && m_flush < CNT_MAX) m_flush++;
    if (stall) begin
      if (m_memw < CNT_MAX) m_memw++;
      m_run++;
      if (m_run >= MEM_TIMEOUT) m_err = 1'b1;
    end else begin
      m_run = 0;
    end
    m_waiting = stall;
    checkCounters(tag);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    m_waiting = 0; m_run = 0; m_stall = 0; m_flush = 0; m_memw = 0; m_err = 0;
    checkOutput("rst_ctrl", 32'(outVec()), 32'd0);
    checkCounters("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    doReset();
    step("idle");

    // Non-load EX dependency on src1.
    applyStimulus(4'd3, 4'd0, 0, 1, 4'd3, 1, 0, 0, 4'd0, 0, 0, 0);
    step("hz_alu");
`ifdef FORWARDING_EN
    checkOutput("hz_alu_cnt", 32'(stall_cnt), 32'd0);
`else
    checkOutput("hz_alu_cnt", 32'(stall_cnt), 32'd1);
`endif

    // Load-use bubbles in both configurations.
    applyStimulus(4'd3, 4'd0, 0, 1, 4'd3, 1, 1, 0, 4'd0, 0, 0, 0);
    step("hz_load");

    // Branch beats the hazard.
    applyStimulus(4'd3, 4'd0, 0, 1, 4'd3, 1, 1, 1, 4'd0, 0, 0, 0);
    step("br_hz");
    checkOutput("br_hz_flush", 32'(flush_cnt), 32'd1);

    // Four wait cycles, branch pending: freezes only.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd3, 4'd0, 0, 1, 4'd3, 1, 1, 1, 4'd0, 0, 1, 0);
      step("memwait");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("memdone");
    checkOutput("memwait_cnt", 32'(mem_wait_cnt), 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("back_idle");

    // Single-cycle access completes without a stall.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("fast_mem");

    // Long wait reaching the timeout.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("longwait");
      if (i == 253) checkOutput("timeout_early", 32'(mem_timeout_err), 32'd0);
    end
    checkOutput("timeout_set", 32'(mem_timeout_err), 32'd1);
    checkOutput("memw_sat", 32'(mem_wait_cnt), 32'(CNT_MAX));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("longdone");
    checkOutput("timeout_sticky", 32'(mem_timeout_err), 32'd1);

    // Reset in the middle of a wait.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("prerst");
    end
    doReset();
    step("postrst");

    // Random traffic with a narrow register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 1'($urandom_range(0, 3) != 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
